// File: rtl/alu_accum_if.sv
// Operand/handshake/result bundle for the bit-serial accumulator ALU.
interface alu_accum_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = WIDTH / 4
);
    logic [WIDTH-1:0]    x;
    logic [1:0]          op;
    logic                go;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    acc;
    logic                carry;
    logic                ovf;
    logic [7*DIGITS-1:0] hex;

    modport master (output x, op, go, input busy, done, acc, carry, ovf, hex);
    modport slave  (input x, op, go, output busy, done, acc, carry, ovf, hex);
endinterface

// File: rtl/alu_accum.sv
// Bit-serial accumulator ALU: ADD/SUB one bit per clock through a single full adder,
// LOAD/CLEAR in one clock, with an active-low hex display of the accumulator.
module alu_accum #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = WIDTH / 4
) (
    input  logic       clock,
    input  logic       reset,
    alu_accum_if.slave bus
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_acc;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_r;
    logic [KW-1:0]       r_k;
    logic                r_c;
    logic                r_sub;
    logic                r_carry;
    logic                r_ovf;

    logic                w_a_bit;
    logic                w_b_bit;
    logic                w_sum;
    logic                w_cout;
    logic                w_last;
    logic [WIDTH-1:0]    w_res;
    logic [7*DIGITS-1:0] w_hex;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // One full-adder slice; subtraction uses the inverted operand with carry-in 1.
    assign w_a_bit = r_acc[r_k];
    assign w_b_bit = r_b[r_k] ^ r_sub;
    assign w_sum   = w_a_bit ^ w_b_bit ^ r_c;
    assign w_cout  = (w_a_bit & w_b_bit) | (w_a_bit & r_c) | (w_b_bit & r_c);
    assign w_last  = (r_k == KW'(WIDTH - 1));
    assign w_res   = r_r | (WIDTH'(w_sum) << r_k);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.go) w_next = bus.op[1] ? S_DONE : S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_k     <= '0;
            r_c     <= 1'b0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_b   <= bus.x;
                        r_sub <= bus.op[0];
                        case (bus.op)
                            OP_ADD, OP_SUB: begin
                                r_k <= '0;
                                r_c <= bus.op[0];
                                r_r <= '0;
                            end
                            OP_LOAD: begin
                                r_acc   <= bus.x;
                                r_carry <= 1'b0;
                                r_ovf   <= 1'b0;
                            end
                            default: begin
                                r_acc   <= '0;
                                r_carry <= 1'b0;
                                r_ovf   <= 1'b0;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    r_r <= w_res;
                    r_c <= w_cout;
                    r_k <= r_k + KW'(1);
                    // Last bit commits directly; r_c here is the carry into the MSB.
                    if (w_last) begin
                        r_acc   <= w_res;
                        r_carry <= w_cout;
                        r_ovf   <= r_c ^ w_cout;
                        r_k     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_hex = '0;
        for (int d = 0; d < DIGITS; d++) begin
            w_hex[7*d +: 7] = seg7(r_acc[4*d +: 4]);
        end
    end

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.acc   = r_acc;
    assign bus.carry = r_carry;
    assign bus.ovf   = r_ovf;
    assign bus.hex   = w_hex;
endmodule

// File: doc/alu_accum.md
# alu_accum

Parametrised bit-serial accumulator ALU with a hex display output. An operand word is applied with a one-cycle `go` strobe. The selected operation is applied to the internal accumulator: ADD and SUB run one bit per clock through a single full-adder stage; LOAD and CLEAR complete in one clock. The accumulator, carry/borrow and signed-overflow flags drive a bank of active-low 7-segment digits. It is the lab-board accumulator stage, generalised in width, with subtract/load/clear modes and a busy/done handshake.

## Interface
- `WIDTH`, default 8: accumulator and operand width in bits. Must be a multiple of 4 and at least 4.
- `DIGITS`, default `WIDTH/4`: number of hex display digits. Derived; do not override.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `x` in WIDTH: operand. Sampled only on the edge where `go` is accepted.
- `op` in 2: operation select, sampled with `x`. 00 ADD (acc+x), 01 SUB (acc−x), 10 LOAD (acc=x), 11 CLEAR (acc=0).
- `go` in 1: start strobe. Accepted only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: high for exactly one cycle when the result is committed.
- `acc` out WIDTH: accumulator value.
- `carry` out 1: carry-out of the last ADD; for SUB, 1 = no borrow (acc ≥ x unsigned).
- `ovf` out 1: two's-complement overflow of the last ADD/SUB.
- `hex` out 7*DIGITS: segment outputs, active-low.
  - Digit d shows `acc[4d+3:4d]` and occupies `hex[7d+6:7d]`.
  - Within a digit, bit 7d+6 = segment a … bit 7d = segment g.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `go`=1: capture `x` into operand register B and `op` into the op register.
  - ADD/SUB: go to RUN with bit index k=0.
    - Carry-in c=0 for ADD, c=1 for SUB.
    - For SUB, B is used inverted.
    - Shadow result register R is cleared.
  - LOAD: `acc`←x, `carry`←0, `ovf`←0; go to DONE.
  - CLEAR: `acc`←0, `carry`←0, `ovf`←0; go to DONE.
- RUN, each cycle: R[k] ← acc[k] ^ B'[k] ^ c; c ← majority(acc[k], B'[k], c); k ← k+1.
  - When k=WIDTH−1, commit in the same edge: `acc`←R (including the bit being computed), `carry`←final c, `ovf`←(carry into MSB) ^ (carry out of MSB). Then go to DONE.
  - `acc` stays unchanged throughout RUN; only R is written.
- DONE: `done`=1 for one cycle, then unconditionally return to IDLE.
- `go` in RUN or DONE is ignored; it is not queued.
- Arithmetic is modulo 2^WIDTH; no saturation.
- k counter width is clog2(WIDTH); it must not wrap before reaching WIDTH−1.
- Display encoding, abcdefg, MSB = a:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - `hex` is combinational from `acc`; no latches (full case).
- Reset: state=IDLE, `acc`=0, B=0, R=0, k=0, `carry`=0, `ovf`=0, `busy`=0, `done`=0, every digit=0000001.
- Reset asserted mid-RUN or in DONE aborts immediately with no commit and no `done` pulse.

## Timing
- Let E0 be the edge at which `go` is accepted.
- ADD/SUB:
  - `busy` rises after E0.
  - Commit at edge E_WIDTH (RUN occupies WIDTH cycles).
  - `done` and the new `acc`/flags are visible in the cycle after E_WIDTH.
  - IDLE after E_WIDTH+1.
  - Minimum go-to-go spacing is WIDTH+2 cycles.
- LOAD/CLEAR:
  - Commit at E0; `done`=1 in the cycle after E0.
  - IDLE after E1; minimum spacing 2 cycles.
- `done` and `busy` are registered state decodes. `busy` is high during the `done` cycle.
- `hex` follows `acc` combinationally; it changes only in the cycle after a commit.

## Test plan
- Reset: assert `reset` asynchronously between edges → `acc`=0, `busy`=0, `done`=0, `carry`=`ovf`=0, all digits 0000001 without waiting for a clock edge.
- WIDTH=8, LOAD 0x7F, then ADD 0x01 → `done` exactly 8 cycles after E0, `acc`=0x80, `carry`=0, `ovf`=1, `hex` digits "8","0" (0000000, 0000001).
- From 0x80, ADD 0xFF → `acc`=0x7F, `carry`=1, `ovf`=1; `acc` must hold 0x80 in every RUN cycle before commit.
- LOAD 0x05, SUB 0x07 → `acc`=0xFE, `carry`=0, `ovf`=0, digits "F","E". Then LOAD 0x05, SUB 0x05 → `acc`=0x00, `carry`=1. Then LOAD 0x80, SUB 0x01 → 0x7F, `ovf`=1.
- Hold `go`=1 continuously with ADD 0x01 from 0 → `acc` increments once every 10 cycles. Toggle `go` during RUN → no extra operation. CLEAR → `acc`=0, flags 0, `done` 1 cycle after E0.
- Assert `reset` at RUN k=3 → immediate IDLE, no `done`, `acc`=0. A subsequent ADD 0x2A → 0x2A. Repeat the ADD and LOAD checks with WIDTH=4 and WIDTH=16 (16: ADD 0xFFFF+0x0001 → 0x0000, `carry`=1, `done` at 16 cycles).
